branch_predictor_gshare: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage core. Successor to the fixed predictor.

---
 rtl/branch_predictor_gshare.sv | 155 +++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare
//   Dynamic branch predictor for the 5-stage core. It predicts in IF,
//   combinationally from the fetch PC, using a table of 2-bit counters (BHT)
//   and a direct-mapped target buffer (BTB). The BHT index can be hashed with
//   a global history register (gshare). Branches resolve in ID, using the
//   prediction values that the pipeline carried from IF. A mispredict raises
//   flush and supplies the redirect address. Two saturating counters track
//   resolved branches and mispredicts.
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   pc_if           fetch PC (word aligned)
//   bp_o            predict taken (counter msb set and BTB hit)
//   btb_target_o    predicted target, 0 on BTB miss
//   bht_idx_o       BHT index used for this prediction
//   upd_valid       ID holds a valid instruction
//   upd_hold        ID stalled this cycle
//   upd_pc          PC of the instruction in ID
//   upd_is_br       instruction in ID is a branch or jump
//   upd_taken       resolved direction
//   upd_target      resolved target
//   upd_bp          prediction carried from IF
//   upd_btb_tgt     predicted target carried from IF
//   upd_bht_idx     BHT index carried from IF
//   flush           mispredict: squash IF/ID and redirect
//   pc_correct      redirect address (0 when no flush)
//   br_count        resolved branches (saturating)
//   mp_count        mispredicts (saturating)
module branch_predictor_gshare #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_BITS    = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          pc_if,
  output logic                           bp_o,
  output logic [ADDR_WIDTH-1:0]          btb_target_o,
  output logic [$clog2(BHT_ENTRIES)-1:0] bht_idx_o,
  input  logic                           upd_valid,
  input  logic                           upd_hold,
  input  logic [ADDR_WIDTH-1:0]          upd_pc,
  input  logic                           upd_is_br,
  input  logic                           upd_taken,
  input  logic [ADDR_WIDTH-1:0]          upd_target,
  input  logic                           upd_bp,
  input  logic [ADDR_WIDTH-1:0]          upd_btb_tgt,
  input  logic [$clog2(BHT_ENTRIES)-1:0] upd_bht_idx,
  output logic                           flush,
  output logic [ADDR_WIDTH-1:0]          pc_correct,
  output logic [CNT_WIDTH-1:0]           br_count,
  output logic [CNT_WIDTH-1:0]           mp_count
);

  localparam int BHT_BITS = $clog2(BHT_ENTRIES);
  localparam int BTB_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_W    = ADDR_WIDTH - BTB_BITS - 2;
  // A register must have at least one bit; when GHR_BITS is 0 it stays at zero.
  localparam int GHR_W    = (GHR_BITS > 0) ? GHR_BITS : 1;

  logic [1:0]             bht       [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag   [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  btb_tgt   [BTB_ENTRIES];
  logic [GHR_W-1:0]       ghr;
  logic [GHR_W-1:0]       ghr_shift;
  logic [BHT_BITS-1:0]    hist;

  logic [BHT_BITS-1:0]    pred_bht_idx;
  logic [BTB_BITS-1:0]    pred_btb_idx;
  logic [TAG_W-1:0]       pred_tag;
  logic                   pred_hit;
  logic [BTB_BITS-1:0]    upd_btb_idx;
  logic [TAG_W-1:0]       upd_tag;
  logic                   eff;

  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_if[1:0];

  always_comb begin
    hist = '0;
    if (GHR_BITS > 0) hist[GHR_W-1:0] = ghr;
  end

  assign ghr_shift = (ghr << 1) | GHR_W'(upd_taken);

  // Prediction path. It reads the arrays directly, so a write in the same
  // cycle becomes visible only after the clock edge.
  always_comb begin
    pred_bht_idx = pc_if[BHT_BITS+1:2] ^ hist;
    pred_btb_idx = pc_if[BTB_BITS+1:2];
    pred_tag     = pc_if[ADDR_WIDTH-1:BTB_BITS+2];
    pred_hit     = btb_valid[pred_btb_idx] && (btb_tag[pred_btb_idx] == pred_tag);
    bp_o         = bht[pred_bht_idx][1] && pred_hit;
    btb_target_o = pred_hit ? btb_tgt[pred_btb_idx] : '0;
    bht_idx_o    = pred_bht_idx;
  end

  assign eff         = upd_valid && !upd_hold;
  assign upd_btb_idx = upd_pc[BTB_BITS+1:2];
  assign upd_tag     = upd_pc[ADDR_WIDTH-1:BTB_BITS+2];

  // The two redirect conditions are mutually exclusive. A taken resolution
  // can only take the first branch, and a not-taken or non-branch one can
  // only take the second.
  always_comb begin
    flush      = 1'b0;
    pc_correct = '0;
    if (eff) begin
      if (upd_is_br && upd_taken && (!upd_bp || (upd_btb_tgt != upd_target))) begin
        flush      = 1'b1;
        pc_correct = upd_target;
      end else if (upd_bp && (!upd_is_br || !upd_taken)) begin
        flush      = 1'b1;
        pc_correct = upd_pc + ADDR_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      btb_valid <= '0;
      ghr       <= '0;
      br_count  <= '0;
      mp_count  <= '0;
    end else if (eff) begin
      if (upd_is_br) begin
        if (upd_taken) begin
          if (bht[upd_bht_idx] != 2'b11) bht[upd_bht_idx] <= bht[upd_bht_idx] + 2'd1;
          btb_valid[upd_btb_idx] <= 1'b1;
        end else if (bht[upd_bht_idx] != 2'b00) begin
          bht[upd_bht_idx] <= bht[upd_bht_idx] - 2'd1;
        end
        if (GHR_BITS > 0) ghr <= ghr_shift;
        if (br_count != '1) br_count <= br_count + CNT_WIDTH'(1);
        if (flush && (mp_count != '1)) mp_count <= mp_count + CNT_WIDTH'(1);
      end else if (upd_bp) begin
        btb_valid[upd_btb_idx] <= 1'b0;
        if (mp_count != '1) mp_count <= mp_count + CNT_WIDTH'(1);
      end
    end
  end

  // Tag and target storage needs no reset because btb_valid qualifies it.
  // It is still gated by rst so that no write happens while reset is held.
  always_ff @(posedge clk) begin
    if (rst && eff && upd_is_br && upd_taken) begin
      btb_tag[upd_btb_idx] <= upd_tag;
      btb_tgt[upd_btb_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
module tb_branch_predictor_gshare;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus set 0 drives u0 (gshare) and u2 (gshare, 4-bit counters).
  // Stimulus set 1 drives u1 (bimodal).
  logic [31:0] pc_if       [2];
  logic        upd_valid   [2];
  logic        upd_hold    [2];
  logic [31:0] upd_pc      [2];
  logic        upd_is_br   [2];
  logic        upd_taken   [2];
  logic [31:0] upd_target  [2];
  logic        upd_bp      [2];
  logic [31:0] upd_btb_tgt [2];
  logic [5:0]  upd_bht_idx [2];

  logic        bp0, bp1, bp2, fl0, fl1, fl2;
  logic [31:0] tg0, tg1, tg2, pcc0, pcc1, pcc2;
  logic [5:0]  ix0, ix1, ix2;
  logic [31:0] br0, mp0, br1, mp1;
  logic [3:0]  br2, mp2;

  int checks = 0;
  int passed = 0;

  branch_predictor_gshare #(.GHR_BITS(6)) u0 (
    .clk(clk), .rst(rst), .pc_if(pc_if[0]), .bp_o(bp0), .btb_target_o(tg0), .bht_idx_o(ix0),
    .upd_valid(upd_valid[0]), .upd_hold(upd_hold[0]), .upd_pc(upd_pc[0]), .upd_is_br(upd_is_br[0]),
    .upd_taken(upd_taken[0]), .upd_target(upd_target[0]), .upd_bp(upd_bp[0]),
    .upd_btb_tgt(upd_btb_tgt[0]), .upd_bht_idx(upd_bht_idx[0]),
    .flush(fl0), .pc_correct(pcc0), .br_count(br0), .mp_count(mp0));

  branch_predictor_gshare #(.GHR_BITS(0)) u1 (
    .clk(clk), .rst(rst), .pc_if(pc_if[1]), .bp_o(bp1), .btb_target_o(tg1), .bht_idx_o(ix1),
    .upd_valid(upd_valid[1]), .upd_hold(upd_hold[1]), .upd_pc(upd_pc[1]), .upd_is_br(upd_is_br[1]),
    .upd_taken(upd_taken[1]), .upd_target(upd_target[1]), .upd_bp(upd_bp[1]),
    .upd_btb_tgt(upd_btb_tgt[1]), .upd_bht_idx(upd_bht_idx[1]),
    .flush(fl1), .pc_correct(pcc1), .br_count(br1), .mp_count(mp1));

  branch_predictor_gshare #(.GHR_BITS(6), .CNT_WIDTH(4)) u2 (
    .clk(clk), .rst(rst), .pc_if(pc_if[0]), .bp_o(bp2), .btb_target_o(tg2), .bht_idx_o(ix2),
    .upd_valid(upd_valid[0]), .upd_hold(upd_hold[0]), .upd_pc(upd_pc[0]), .upd_is_br(upd_is_br[0]),
    .upd_taken(upd_taken[0]), .upd_target(upd_target[0]), .upd_bp(upd_bp[0]),
    .upd_btb_tgt(upd_btb_tgt[0]), .upd_bht_idx(upd_bht_idx[0]),
    .flush(fl2), .pc_correct(pcc2), .br_count(br2), .mp_count(mp2));

  task automatic set_upd(input int k, input logic v, input logic h, input logic [31:0] pc,
                         input logic br, input logic tk, input logic [31:0] tgt,
                         input logic bp, input logic [31:0] btgt, input logic [5:0] idx);
    upd_valid[k] = v;  upd_hold[k] = h;    upd_pc[k] = pc;     upd_is_br[k] = br;
    upd_taken[k] = tk; upd_target[k] = tgt; upd_bp[k] = bp;    upd_btb_tgt[k] = btgt;
    upd_bht_idx[k] = idx;
  endtask

  task automatic idle(input int k);
    set_upd(k, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(0); idle(1);
    pc_if[0] = 32'h100; pc_if[1] = 32'h100;
    #3;
    checks++; if (bp0 !== 1'b0) $display("FAIL reset_bp: got %0h want 0", bp0); else passed++;
    checks++; if (tg0 !== 32'h0) $display("FAIL reset_tgt: got %0h want 0", tg0); else passed++;
    checks++; if (fl0 !== 1'b0) $display("FAIL reset_flush: got %0h want 0", fl0); else passed++;
    checks++; if (pcc0 !== 32'h0) $display("FAIL reset_pc_correct: got %0h want 0", pcc0); else passed++;
    checks++; if (br0 !== 32'h0 || mp0 !== 32'h0) $display("FAIL reset_counters: got br=%0h mp=%0h want 0 0", br0, mp0); else passed++;
    checks++; if (bp1 !== 1'b0 || tg1 !== 32'h0) $display("FAIL reset_bimodal: got bp=%0h tgt=%0h want 0 0", bp1, tg1); else passed++;
    @(negedge clk) rst = 1'b1;
  endtask

  // Branch at 0x100 to 0x80, resolved taken twice with no traced prediction.
  task automatic test_taken_learn();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      set_upd(0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 6'(n)); // GHR 0 then 1
      set_upd(1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 6'd0);
      #1;
      checks++; if (fl0 !== 1'b1 || pcc0 !== 32'h80) $display("FAIL taken_flush_%0d: got flush=%0h pc=%0h want 1 80", n, fl0, pcc0); else passed++;
      checks++; if (fl1 !== 1'b1 || pcc1 !== 32'h80) $display("FAIL taken_flush_bimodal_%0d: got flush=%0h pc=%0h want 1 80", n, fl1, pcc1); else passed++;
    end
    @(negedge clk); idle(0); idle(1); #1;
    checks++; if (bp1 !== 1'b1 || tg1 !== 32'h80) $display("FAIL learned_bimodal: got bp=%0h tgt=%0h want 1 80", bp1, tg1); else passed++;
    // gshare: history 000011 hashes to a still weakly-not-taken entry
    checks++; if (ix0 !== 6'd3 || bp0 !== 1'b0 || tg0 !== 32'h80) $display("FAIL learned_gshare: got idx=%0d bp=%0h tgt=%0h want 3 0 80", ix0, bp0, tg0); else passed++;
    checks++; if (br0 !== 32'd2 || mp0 !== 32'd2) $display("FAIL learned_counts: got br=%0d mp=%0d want 2 2", br0, mp0); else passed++;
  endtask

  // Predicted-taken branch resolves not taken twice on the bimodal unit: 3->2->1.
  task automatic test_mispredict_nt();
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      set_upd(1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80, 6'd0);
      #1;
      checks++; if (fl1 !== 1'b1 || pcc1 !== 32'h104) $display("FAIL nt_flush_%0d: got flush=%0h pc=%0h want 1 104", n, fl1, pcc1); else passed++;
      @(negedge clk); idle(1); #1;
      checks++; if (mp1 !== 32'(3 + n) || br1 !== 32'(3 + n)) $display("FAIL nt_counts_%0d: got mp=%0d br=%0d want %0d", n, mp1, br1, 3 + n); else passed++;
      checks++; if (bp1 !== (n == 0)) $display("FAIL nt_counter_%0d: got bp=%0h want %0h", n, bp1, n == 0); else passed++;
    end
  endtask

  task automatic test_hold();
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      set_upd(0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0, 32'h80, 6'd3);
      #1;
      checks++; if (fl0 !== 1'b0) $display("FAIL hold_flush_%0d: got %0h want 0", h, fl0); else passed++;
      @(posedge clk); #1;
      checks++; if (br0 !== 32'd2) $display("FAIL hold_br_%0d: got %0d want 2", h, br0); else passed++;
    end
    @(negedge clk); upd_hold[0] = 1'b0; #1;
    checks++; if (fl0 !== 1'b1 || pcc0 !== 32'h300) $display("FAIL release_flush: got flush=%0h pc=%0h want 1 300", fl0, pcc0); else passed++;
    @(posedge clk); #1;
    checks++; if (br0 !== 32'd3 || mp0 !== 32'd3) $display("FAIL release_counts: got br=%0d mp=%0d want 3 3", br0, mp0); else passed++;
    @(negedge clk); idle(0); #1;
    checks++; if (tg0 !== 32'h300 || br0 !== 32'd3) $display("FAIL release_btb: got tgt=%0h br=%0d want 300 3", tg0, br0); else passed++;
  endtask

  // A predicted-taken non-branch invalidates its BTB entry.
  task automatic test_invalidate();
    @(negedge clk);
    set_upd(0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 6'd0);
    #1;
    checks++; if (fl0 !== 1'b1 || pcc0 !== 32'h104) $display("FAIL inval_flush: got flush=%0h pc=%0h want 1 104", fl0, pcc0); else passed++;
    @(negedge clk); idle(0); #1;
    checks++; if (tg0 !== 32'h0 || bp0 !== 1'b0) $display("FAIL inval_btb: got tgt=%0h bp=%0h want 0 0", tg0, bp0); else passed++;
    checks++; if (mp0 !== 32'd4 || br0 !== 32'd3) $display("FAIL inval_counts: got mp=%0d br=%0d want 4 3", mp0, br0); else passed++;
  endtask

  // Alternating T/NT on one PC, with prediction traced into the update.
  task automatic test_history();
    @(negedge clk) rst = 1'b0;
    idle(0); idle(1);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      idle(0); idle(1);
      pc_if[0] = 32'h100; pc_if[1] = 32'h100;
      #1;
      if (i == 8) begin
        checks++; if (mp0 !== 32'd4) $display("FAIL gshare_warmup_mp: got %0d want 4", mp0); else passed++;
      end
      set_upd(0, 1'b1, 1'b0, 32'h100, 1'b1, (i % 2) == 0, 32'h200, bp0, tg0, ix0);
      set_upd(1, 1'b1, 1'b0, 32'h100, 1'b1, (i % 2) == 0, 32'h200, bp1, tg1, ix1);
    end
    @(negedge clk); idle(0); idle(1); #1;
    checks++; if (mp0 !== 32'd4 || br0 !== 32'd32) $display("FAIL gshare_counts: got mp=%0d br=%0d want 4 32", mp0, br0); else passed++;
    checks++; if (mp1 !== 32'd32 || br1 !== 32'd32) $display("FAIL bimodal_counts: got mp=%0d br=%0d want 32 32", mp1, br1); else passed++;
    checks++; if (mp2 !== 4'd4 || br2 !== 4'd15) $display("FAIL narrow_counts: got mp=%0d br=%0d want 4 15", mp2, br2); else passed++;
  endtask

  task automatic test_saturate();
    int exp_mp;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      set_upd(0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 6'd0);
      @(posedge clk); #1;
      exp_mp = (4 + j > 15) ? 15 : 4 + j;
      checks++; if (mp2 !== 4'(exp_mp)) $display("FAIL sat_mp_%0d: got %0d want %0d", j, mp2, exp_mp); else passed++;
    end
    @(negedge clk); idle(0); #1;
    checks++; if (mp0 !== 32'd24 || br0 !== 32'd52) $display("FAIL wide_counts: got mp=%0d br=%0d want 24 52", mp0, br0); else passed++;
    checks++; if (br2 !== 4'd15) $display("FAIL sat_br: got %0d want 15", br2); else passed++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pc_if[0] = 32'h100;
    set_upd(0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 6'd0);
    #2 rst = 1'b0;
    #1;
    checks++; if (br0 !== 32'd0 || mp0 !== 32'd0 || mp2 !== 4'd0) $display("FAIL async_counts: got br=%0d mp=%0d mp2=%0d want 0 0 0", br0, mp0, mp2); else passed++;
    checks++; if (tg0 !== 32'h0 || bp0 !== 1'b0 || ix0 !== 6'd0) $display("FAIL async_pred: got tgt=%0h bp=%0h idx=%0d want 0 0 0", tg0, bp0, ix0); else passed++;
    @(posedge clk); #1;
    checks++; if (br0 !== 32'd0 || tg0 !== 32'h0) $display("FAIL async_hold: got br=%0d tgt=%0h want 0 0", br0, tg0); else passed++;
    @(negedge clk); idle(0); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (br0 !== 32'd0 || tg0 !== 32'h0) $display("FAIL async_release: got br=%0d tgt=%0h want 0 0", br0, tg0); else passed++;
  endtask

  initial begin
    test_reset();
    test_taken_learn();
    test_mispredict_nt();
    test_hold();
    test_invalidate();
    test_history();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
